// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and baud-rate helper
//   uart_rx_state_t : receiver FSM states
//   UART_DATA_BITS  : data bits per frame
//   clks_per_bit()  : integer clocks per serial bit
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input
//   clk : destination clock
//   rst : asynchronous active-high reset, both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronized output
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready output and error pulses
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   rx_serial : asynchronous serial line, idle high
//   rx_data   : received byte, stable while rx_valid
//   rx_valid  : byte available, held until accepted
//   rx_ready  : consumer accepts on rx_valid && rx_ready
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : one-cycle pulse when a byte completes while the previous is unaccepted
//   busy      : receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);

    if (CLKS_PER_BIT < 4) begin : g_bad_rate
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    uart_rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [UART_DATA_BITS-1:0] shift, shift_n;
    logic rx_s, done, ferr, half, tick;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx_serial),
        .q  (rx_s)
    );

    assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign tick = cnt == CW'(CLKS_PER_BIT - 1);
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
        end
    end

    // START re-samples at half a bit so every later tick lands mid-bit
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift;
        done    = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (half) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[UART_DATA_BITS-1:1]};
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == BW'(UART_DATA_BITS - 1)) state_n = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_n   = '0;
                    done    = rx_s;
                    ferr    = !rx_s;
                    state_n = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // a completing byte may replace the held one only if it is being accepted now
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= done && rx_valid && !rx_ready;
            if (done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
